// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port (CPU / debug) data-memory arbiter. CPU has priority
//            unless the debug port has been starved for STARVE_LIMIT cycles.
//            Accesses at or above IO_BASE insert a one-cycle hold during
//            which nothing is granted. Read data comes back one cycle after
//            the grant and is routed to the port that issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int                 DBITS        = 32,
  parameter int                 STARVE_LIMIT = 4,
  parameter logic [DBITS-1:0]   IO_BASE      = 32'hF0000000
) (
  input  logic             clk,
  input  logic             reset,
  // CPU memory-stage port
  input  logic             c_req,
  input  logic             c_we,
  input  logic [DBITS-1:0] c_addr,
  input  logic [DBITS-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [DBITS-1:0] c_rdata,
  output logic             c_stall,
  // Debug / DMA port
  input  logic             d_req,
  input  logic             d_we,
  input  logic [DBITS-1:0] d_addr,
  input  logic [DBITS-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DBITS-1:0] d_rdata,
  // Data memory
  output logic             m_wrtEn,
  output logic [DBITS-1:0] m_addr,
  output logic [DBITS-1:0] m_dIn,
  input  logic [DBITS-1:0] m_dOut
);

  localparam logic [0:0] c_ST_IDLE    = 1'b0;
  localparam logic [0:0] c_ST_IO_HOLD = 1'b1;
  localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_LIMIT);

  logic [0:0] r_state;
  logic [3:0] r_starve_cnt;
  logic       r_c_owner;
  logic       r_d_owner;

  logic       w_idle;
  logic       w_starved;
  logic       w_io_hit;

  // Grants are only possible out of reset and in IDLE; gating with reset
  // keeps every combinational output at zero while reset is asserted.
  assign w_idle    = reset && (r_state == c_ST_IDLE);
  assign w_starved = (r_starve_cnt == c_STARVE_LIM);

  // Priority decision: CPU first, debug when it has waited long enough
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (w_idle) begin
      if (c_req && d_req) begin
        d_gnt = w_starved;
        c_gnt = !w_starved;
      end else begin
        c_gnt = c_req;
        d_gnt = d_req;
      end
    end
  end

  assign c_stall = c_req && !c_gnt;

  // Memory-side mux driven by whichever port holds the grant
  always_comb begin
    m_wrtEn = 1'b0;
    m_addr  = '0;
    m_dIn   = '0;
    if (c_gnt) begin
      m_wrtEn = c_we;
      m_addr  = c_addr;
      m_dIn   = c_wdata;
    end else if (d_gnt) begin
      m_wrtEn = d_we;
      m_addr  = d_addr;
      m_dIn   = d_wdata;
    end
  end

  assign w_io_hit = (c_gnt || d_gnt) && (m_addr >= IO_BASE);

  // Read return: the owner register selects which port sees m_dOut
  assign c_rvalid = r_c_owner;
  assign d_rvalid = r_d_owner;
  assign c_rdata  = r_c_owner ? m_dOut : '0;
  assign d_rdata  = r_d_owner ? m_dOut : '0;

  // State, starvation counter and read-owner tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_ST_IDLE;
      r_starve_cnt <= 4'd0;
      r_c_owner    <= 1'b0;
      r_d_owner    <= 1'b0;
    end else begin
      r_c_owner <= c_gnt && !c_we;
      r_d_owner <= d_gnt && !d_we;

      case (r_state)
        c_ST_IDLE:    r_state <= w_io_hit ? c_ST_IO_HOLD : c_ST_IDLE;
        c_ST_IO_HOLD: r_state <= c_ST_IDLE;
        default:      r_state <= c_ST_IDLE;
      endcase

      if (d_gnt) begin
        r_starve_cnt <= 4'd0;
      end else if (d_req && (r_starve_cnt < c_STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed scenarios with
//            literal expectations plus randomized traffic compared against a
//            behavioural model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int          DBITS   = 32;
  localparam int          STARVE  = 4;
  localparam logic [31:0] IO_BASE = 32'hF0000000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             c_req = 1'b0, c_we = 1'b0;
  logic [DBITS-1:0] c_addr = '0, c_wdata = '0;
  logic             c_gnt, c_rvalid, c_stall;
  logic [DBITS-1:0] c_rdata;
  logic             d_req = 1'b0, d_we = 1'b0;
  logic [DBITS-1:0] d_addr = '0, d_wdata = '0;
  logic             d_gnt, d_rvalid;
  logic [DBITS-1:0] d_rdata;
  logic             m_wrtEn;
  logic [DBITS-1:0] m_addr, m_dIn;
  logic [DBITS-1:0] m_dOut = '0;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: hold cycles left, consecutive debug denials,
  // and who receives read data next cycle (0 none, 1 CPU, 2 debug).
  int hold_left = 0;
  int denied    = 0;
  int owner     = 0;
  bit e_cg, e_dg;

  dmem_arbiter #(.DBITS(DBITS), .STARVE_LIMIT(STARVE), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_wrtEn(m_wrtEn), .m_addr(m_addr), .m_dIn(m_dIn), .m_dOut(m_dOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hold_left = 0;
    denied    = 0;
    owner     = 0;
  endtask

  // Compare every DUT output with what the arbitration rules demand now
  task automatic model_check();
    logic [31:0] ea, ed;
    bit          ew;
    if (!reset) model_reset();
    e_cg = 0;
    e_dg = 0;
    if (reset && hold_left == 0) begin
      if (c_req && d_req) begin
        e_dg = (denied == STARVE);
        e_cg = !e_dg;
      end else begin
        e_cg = c_req;
        e_dg = d_req;
      end
    end
    ea = e_cg ? c_addr  : (e_dg ? d_addr  : 32'h0);
    ed = e_cg ? c_wdata : (e_dg ? d_wdata : 32'h0);
    ew = e_cg ? c_we    : (e_dg ? d_we    : 1'b0);
    chk("c_gnt",    32'(c_gnt),    32'(e_cg));
    chk("d_gnt",    32'(d_gnt),    32'(e_dg));
    chk("c_stall",  32'(c_stall),  32'(c_req && !e_cg));
    chk("m_wrtEn",  32'(m_wrtEn),  32'(ew));
    chk("m_addr",   m_addr,        ea);
    chk("m_dIn",    m_dIn,         ed);
    chk("c_rvalid", 32'(c_rvalid), 32'(owner == 1));
    chk("d_rvalid", 32'(d_rvalid), 32'(owner == 2));
    chk("c_rdata",  c_rdata,       (owner == 1) ? m_dOut : 32'h0);
    chk("d_rdata",  d_rdata,       (owner == 2) ? m_dOut : 32'h0);
  endtask

  // Advance the model across the coming rising edge
  task automatic model_advance();
    logic [31:0] ga;
    if (!reset) begin
      model_reset();
    end else begin
      ga = e_cg ? c_addr : d_addr;
      owner = (e_cg && !c_we) ? 1 : ((e_dg && !d_we) ? 2 : 0);
      hold_left = ((e_cg || e_dg) && ga >= IO_BASE) ? 1 : 0;
      if (e_dg)       denied = 0;
      else if (d_req) denied = (denied < STARVE) ? denied + 1 : STARVE;
    end
  endtask

  // One clock cycle: drive at negedge, check shortly after, advance model
  task automatic run_cycle(input logic rst, input logic cr, input logic cw,
                           input logic [31:0] ca, input logic [31:0] cd,
                           input logic dr, input logic dw,
                           input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    reset = rst;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    m_dOut = $urandom;
    #1;
    model_check();
    model_advance();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 3) == 0) ? (IO_BASE | 32'($urandom_range(0, 255)))
                                    : 32'($urandom_range(0, 32'hFFFF));
    return a;
  endfunction

  initial begin
    // Reset held with requests active: everything must read zero
    run_cycle(0, 1, 1, 32'h100, 32'h55, 1, 1, 32'h200, 32'h66);
    chk("rst_c_gnt",   32'(c_gnt),   32'h0);
    chk("rst_m_wrtEn", 32'(m_wrtEn), 32'h0);
    chk("rst_m_addr",  m_addr,       32'h0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // CPU read 0x100 alone
    run_cycle(1, 1, 0, 32'h100, 0, 0, 0, 0, 0);
    chk("r27_c_gnt",  32'(c_gnt),   32'h1);
    chk("r27_m_addr", m_addr,       32'h100);
    chk("r27_m_we",   32'(m_wrtEn), 32'h0);
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r27_c_rvalid", 32'(c_rvalid), 32'h1);
    chk("r27_c_rdata",  c_rdata,       m_dOut);
    chk("r27_d_rvalid", 32'(d_rvalid), 32'h0);

    // Both requesting continuously: debug wins on the fifth cycle
    for (int i = 0; i < 5; i++) begin
      run_cycle(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      chk($sformatf("r28_c_gnt%0d", i),   32'(c_gnt),   (i < 4) ? 32'h1 : 32'h0);
      chk($sformatf("r28_d_gnt%0d", i),   32'(d_gnt),   (i < 4) ? 32'h0 : 32'h1);
      chk($sformatf("r28_c_stall%0d", i), 32'(c_stall), (i < 4) ? 32'h0 : 32'h1);
    end

    // CPU I/O write then a held CPU request during IO_HOLD
    run_cycle(1, 1, 1, 32'hF0000004, 32'h3FF, 0, 0, 0, 0);
    chk("r29_m_we",   32'(m_wrtEn), 32'h1);
    chk("r29_m_addr", m_addr,       32'hF0000004);
    chk("r29_m_dIn",  m_dIn,        32'h3FF);
    run_cycle(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("r29_hold_c_gnt", 32'(c_gnt),   32'h0);
    chk("r29_hold_d_gnt", 32'(d_gnt),   32'h0);
    chk("r29_hold_stall", 32'(c_stall), 32'h1);
    chk("r29_hold_m_we",  32'(m_wrtEn), 32'h0);
    chk("r29_hold_rv",    32'(c_rvalid), 32'h0);
    run_cycle(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("r29_after_c_gnt", 32'(c_gnt), 32'h1);

    // Debug read, then CPU read: data routed to the right owner
    run_cycle(1, 0, 0, 0, 0, 1, 0, 32'h40, 0);
    chk("r30_d_gnt", 32'(d_gnt), 32'h1);
    run_cycle(1, 1, 0, 32'h44, 0, 0, 0, 0, 0);
    chk("r30_c_gnt",    32'(c_gnt),    32'h1);
    chk("r30_d_rvalid", 32'(d_rvalid), 32'h1);
    chk("r30_d_rdata",  d_rdata,       m_dOut);
    chk("r30_c_rdata0", c_rdata,       32'h0);
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r30_c_rvalid", 32'(c_rvalid), 32'h1);
    chk("r30_c_rdata",  c_rdata,       m_dOut);
    chk("r30_d_rvalid2", 32'(d_rvalid), 32'h0);

    // Asynchronous reset while a read is pending
    run_cycle(1, 1, 0, 32'h200, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("r31_c_rvalid", 32'(c_rvalid), 32'h0);
    chk("r31_c_gnt",    32'(c_gnt),    32'h0);
    chk("r31_m_addr",   m_addr,        32'h0);
    run_cycle(0, 1, 0, 32'h200, 0, 0, 0, 0, 0);
    run_cycle(1, 1, 0, 32'h300, 0, 0, 0, 0, 0);
    chk("r31_c_rvalid_post", 32'(c_rvalid), 32'h0);
    chk("r31_c_gnt_post",    32'(c_gnt),    32'h1);

    // Randomized traffic, including occasional resets and I/O accesses
    for (int n = 0; n < 3000; n++) begin
      run_cycle(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 9) < 6), $urandom_range(0, 1), rand_addr(), $urandom,
                ($urandom_range(0, 9) < 6), $urandom_range(0, 1), rand_addr(), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DBITS, default 32, data/address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive denied cycles before the debug port wins priority (range 1..15).
REQ-003 SHALL have parameter IO_BASE, default 32'hF0000000, lowest memory-mapped I/O address.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have ports c_req, c_we  in  1 each  CPU memory-stage request / write select.
REQ-007 SHALL have ports c_addr, c_wdata  in  DBITS each  CPU address / write data.
REQ-008 SHALL have ports c_gnt, c_rvalid  out  1 each  CPU grant / read data valid.
REQ-009 SHALL have port c_rdata  out  DBITS  CPU read data.
REQ-010 SHALL have port c_stall  out  1  pipeline stall (CPU request pending, not granted).
REQ-011 SHALL have ports d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, with the same directions and widths as the c_* equivalents, for the debug/DMA requester.
REQ-012 SHALL have ports m_wrtEn  out  1, m_addr  out  DBITS, m_dIn  out  DBITS  to data memory.
REQ-013 SHALL have port m_dOut  in  DBITS  memory read data, valid one cycle after its address is presented.

Function
REQ-014 SHALL use states IDLE and IO_HOLD; IDLE grants at most one request per cycle; IO_HOLD grants nothing.
REQ-015 In IDLE with exactly one request, SHALL grant it combinationally in the same cycle.
REQ-016 In IDLE with both requesting, SHALL grant CPU unless starve_cnt == STARVE_LIMIT, in which case it SHALL grant debug.
REQ-017 starve_cnt (4 bits) SHALL increment when d_req=1 and d_gnt=0 and saturate at STARVE_LIMIT; it SHALL clear on any d_gnt and hold otherwise.
REQ-018 m_addr/m_dIn SHALL mux from the granted port; m_wrtEn SHALL equal granted port's we AND its gnt; with no grant m_wrtEn=0 and m_addr/m_dIn=0.
REQ-019 A granted read SHALL register its owner; next cycle the owner's rvalid=1 and rdata=m_dOut; the non-owner's rdata=0.
REQ-020 A granted access with addr >= IO_BASE (unsigned) SHALL move to IO_HOLD for exactly one cycle, then return to IDLE.
REQ-021 Read-data return for an I/O read SHALL occur in the IO_HOLD cycle (one cycle after grant), unaffected by the hold.
REQ-022 c_stall SHALL equal c_req AND NOT c_gnt, combinationally.
REQ-023 A request dropped before grant SHALL be discarded with no memory side effect and no rvalid.
REQ-024 Writes SHALL never produce rvalid.

Reset
REQ-025 While reset=0: state=IDLE, starve_cnt=0, read-owner cleared; c_gnt, d_gnt, c_rvalid, d_rvalid, m_wrtEn=0; c_rdata, d_rdata, m_addr, m_dIn=0.
REQ-026 Reset asserted mid-read or in IO_HOLD SHALL drop the pending rvalid; the first cycle after release SHALL behave as IDLE.

Verification
REQ-027 CPU read 0x100 alone -> c_gnt=1 same cycle, m_addr=0x100, m_wrtEn=0; next cycle c_rvalid=1, c_rdata=m_dOut, d_rvalid=0.
REQ-028 Both request continuously, STARVE_LIMIT=4 -> CPU granted cycles 0-3, debug granted cycle 4, starve_cnt back to 0, c_stall=1 only in cycle 4.
REQ-029 CPU write 0xF0000004 data 0x3FF -> m_wrtEn=1 for one cycle, IO_HOLD next cycle with c_gnt=d_gnt=0 and c_stall=1 if c_req held, IDLE after.
REQ-030 Debug read 0x40, then CPU read 0x44 next cycle -> d_rvalid in cycle 1 alongside c_gnt, c_rvalid in cycle 2; rdata routed to correct owner each time.
REQ-031 reset=0 asynchronously during a pending read -> all outputs 0 immediately, no rvalid after release; first request after release granted same cycle.
